// File: rtl/fir_interp2_if.sv
// Sample-stream handshake bundle for the interpolate-by-2 FIR.
// The upstream side is in_*, the downstream side is out_*.
interface fir_interp2_if #(
    parameter int DATA_W = 24
);
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_phase;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_phase
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_phase
    );
endinterface

// File: rtl/fir_interp2.sv
// Polyphase half-band interpolate-by-2 FIR: one input sample in,
// an even-phase and then an odd-phase output sample out.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for an input sample
//   CALC  | delay line just shifted; register both phase results
//   EVEN  | presenting even-phase sample until out_ready
//   ODD   | presenting odd-phase sample until out_ready
module fir_interp2 #(
    parameter int DATA_W = 24,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 40,
    parameter int SHIFT  = 14
) (
    input  logic          clk,
    input  logic          reset,
    fir_interp2_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, EVEN, ODD} state_t;

    localparam int TAPS = 8;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));
    localparam logic signed [COEF_W-1:0] H_CENTER = COEF_W'(16384);

    state_t state, state_next;

    logic signed [DATA_W-1:0] d [TAPS];
    logic signed [DATA_W-1:0] odd_hold;
    logic signed [DATA_W-1:0] data_q;
    logic                     valid_q;
    logic                     phase_q;

    logic                     accept;
    logic                     load_calc;
    logic                     load_odd;
    logic                     done;

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_o;
    logic signed [ACC_W-1:0]  acc_e;
    logic signed [ACC_W-1:0]  acc_o;
    logic signed [DATA_W-1:0] y_e;
    logic signed [DATA_W-1:0] y_o;

    // Even polyphase branch h[2k]; the odd branch is the single centre tap.
    function automatic logic signed [COEF_W-1:0] coef_e(input int k);
        case (k)
            0, 7:    coef_e = COEF_W'(-868);
            1, 6:    coef_e = COEF_W'(1445);
            2, 5:    coef_e = COEF_W'(-3060);
            default: coef_e = COEF_W'(10285);
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (v < SAT_MIN)
            sat = {1'b1, {(DATA_W-1){1'b0}}};
        else
            sat = v[DATA_W-1:0];
    endfunction

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_phase = phase_q;

    assign accept = (state == IDLE) && bus.in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_calc  = 1'b0;
        load_odd   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (bus.in_valid) state_next = CALC;
            CALC: begin
                load_calc  = 1'b1;
                state_next = EVEN;
            end
            EVEN: if (bus.out_ready) begin
                load_odd   = 1'b1;
                state_next = ODD;
            end
            ODD: if (bus.out_ready) begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        prod  = '0;
        acc_e = '0;
        for (int k = 0; k < TAPS; k++) begin
            prod  = d[k] * coef_e(k);
            acc_e = acc_e + ACC_W'(prod);
        end
        prod_o = d[3] * H_CENTER;
        acc_o  = ACC_W'(prod_o);
        y_e    = sat(acc_e >>> SHIFT);
        y_o    = sat(acc_o >>> SHIFT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) d[k] <= '0;
        end else if (accept) begin
            d[0] <= bus.in_data;
            for (int k = 1; k < TAPS; k++) d[k] <= d[k-1];
        end
    end

    // Odd result is captured with the even one so the delay line is free
    // to be reused while the outputs drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= '0;
            odd_hold <= '0;
            valid_q  <= 1'b0;
            phase_q  <= 1'b0;
        end else if (load_calc) begin
            data_q   <= y_e;
            odd_hold <= y_o;
            valid_q  <= 1'b1;
            phase_q  <= 1'b0;
        end else if (load_odd) begin
            data_q   <= odd_hold;
            phase_q  <= 1'b1;
        end else if (done) begin
            valid_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_interp2.sv
// Self-checking bench for fir_interp2: constant vector tables, directed
// corner cases and randomized streams against an arithmetic reference model.
module tb_fir_interp2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fir_interp2_if #(.DATA_W(24)) bus ();

    fir_interp2 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    longint hist [8];
    longint e_coef [8] = '{-868, 1445, -3060, 10285, 10285, -3060, 1445, -868};

    typedef struct {
        int din;
        int ev;
        int od;
    } vec_t;
    vec_t vecs [$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > 8388607) return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) hist[k] = 0;
    endtask

    task automatic model_push(input longint x, output longint ev, output longint od);
        longint acc;
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        acc = 0;
        for (int k = 0; k < 8; k++) acc += hist[k] * e_coef[k];
        ev = clamp(acc >>> 14);
        od = clamp((hist[3] * 16384) >>> 14);
    endtask

    function automatic longint out_val();
        return longint'($signed(bus.out_data));
    endfunction

    // Starts and ends at a falling edge with the DUT in IDLE; out_ready=1.
    task automatic process_sample(input int x, output longint ev, output longint od);
        longint mev, mod;
        model_push(x, mev, mod);
        chk("in_ready_idle", bus.in_ready, 1);
        bus.in_data   = 24'(x);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("calc_valid", bus.out_valid, 0);
        chk("calc_in_ready", bus.in_ready, 0);
        @(negedge clk);
        chk("even_valid", bus.out_valid, 1);
        chk("even_phase", bus.out_phase, 0);
        ev = out_val();
        chk("even_model", ev, mev);
        @(negedge clk);
        chk("odd_valid", bus.out_valid, 1);
        chk("odd_phase", bus.out_phase, 1);
        od = out_val();
        chk("odd_model", od, mod);
        @(negedge clk);
        chk("idle_valid", bus.out_valid, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    task automatic run_stream(input int cycles, input bit b2b);
        longint exp_q [$];
        longint ph_q [$];
        longint mev, mod, want, ph;
        logic [23:0] r;
        int last_acc = -1;
        int n_acc = 0;
        for (int c = 0; c < cycles; c++) begin
            bus.out_ready = b2b ? 1'b1 : 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra_output", 1, 0);
                end else begin
                    want = exp_q.pop_front();
                    ph   = ph_q.pop_front();
                    chk("stream_data", out_val(), want);
                    chk("stream_phase", bus.out_phase, ph);
                end
            end
            r = 24'($urandom);
            bus.in_data  = r;
            bus.in_valid = b2b ? 1'b1 : 1'($urandom_range(0, 1));
            if (bus.in_valid && bus.in_ready) begin
                model_push(longint'($signed(r)), mev, mod);
                exp_q.push_back(mev);  ph_q.push_back(0);
                exp_q.push_back(mod);  ph_q.push_back(1);
                if (b2b && last_acc >= 0) chk("b2b_spacing", c - last_acc, 4);
                last_acc = c;
                n_acc++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            bus.out_ready = 1'b1;
            if (bus.out_valid) begin
                want = exp_q.pop_front();
                ph   = ph_q.pop_front();
                chk("drain_data", out_val(), want);
                chk("drain_phase", bus.out_phase, ph);
            end
            @(negedge clk);
        end
        chk("stream_drained", exp_q.size(), 0);
        if (b2b) chk("b2b_accepts", n_acc, cycles / 4);
        chk("stream_end_valid", bus.out_valid, 0);
    endtask

    initial begin
        longint ev, od, hold_d, mev, mod;
        int sat_pos [8] = '{-8388608, 8388607, -8388608, 8388607,
                            8388607, -8388608, 8388607, -8388608};

        reset = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", out_val(), 0);
        chk("rst_out_phase", bus.out_phase, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        reset = 1'b0;
        @(negedge clk);
        model_reset();

        // Impulse followed by DC; the DC's first sample pushes the impulse out.
        vecs.push_back('{16384, -868, 0});
        vecs.push_back('{0, 1445, 0});
        vecs.push_back('{0, -3060, 0});
        vecs.push_back('{0, 10285, 16384});
        vecs.push_back('{0, 10285, 0});
        vecs.push_back('{0, -3060, 0});
        vecs.push_back('{0, 1445, 0});
        vecs.push_back('{0, -868, 0});
        vecs.push_back('{1000, -53, 0});
        vecs.push_back('{1000, 35, 0});
        vecs.push_back('{1000, -152, 0});
        vecs.push_back('{1000, 476, 1000});
        vecs.push_back('{1000, 1103, 1000});
        vecs.push_back('{1000, 917, 1000});
        vecs.push_back('{1000, 1005, 1000});
        vecs.push_back('{1000, 952, 1000});
        foreach (vecs[i]) begin
            process_sample(vecs[i].din, ev, od);
            chk($sformatf("tbl_even_%0d", i), ev, vecs[i].ev);
            chk($sformatf("tbl_odd_%0d", i), od, vecs[i].od);
        end

        for (int i = 0; i < 8; i++) process_sample(sat_pos[i], ev, od);
        chk("sat_pos_even", ev, 8388607);
        chk("sat_pos_odd", od, 8388607);
        for (int i = 0; i < 8; i++)
            process_sample(sat_pos[i] == -8388608 ? 8388607 : -8388608, ev, od);
        chk("sat_neg_even", ev, -8388608);
        chk("sat_neg_odd", od, -8388608);

        // Reset while an even sample is stalled.
        bus.in_data   = 24'd777;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", bus.out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_data", out_val(), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("postrst_in_ready", bus.in_ready, 1);
        process_sample(16384, ev, od);
        chk("postrst_even", ev, -868);

        // Backpressure in EVEN for 10 cycles and in ODD for 5.
        do_reset();
        for (int i = 0; i < 3; i++) process_sample(int'($urandom_range(0, 200000)) - 100000, ev, od);
        model_push(123456, mev, mod);
        bus.in_data   = 24'd123456;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_even_data", out_val(), mev);
        hold_d = out_val();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 24'($urandom);
            @(negedge clk);
            chk("bp_even_hold", out_val(), hold_d);
            chk("bp_even_phase", bus.out_phase, 0);
            chk("bp_even_valid", bus.out_valid, 1);
            chk("bp_even_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_odd_data", out_val(), mod);
        hold_d = out_val();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 24'($urandom);
            @(negedge clk);
            chk("bp_odd_hold", out_val(), hold_d);
            chk("bp_odd_phase", bus.out_phase, 1);
            chk("bp_odd_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_valid", bus.out_valid, 0);
        for (int i = 0; i < 4; i++) process_sample(int'($urandom_range(0, 2000000)) - 1000000, ev, od);

        run_stream(80, 1'b1);
        run_stream(400, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
